// File: rtl/vtg_pkg.sv
// Shared types and default VIC-family raster geometry for the video timing generator.
// Boards with a different raster override this one set of localparams.
package vtg_pkg;

  typedef enum logic [0:0] {StIdle, StGrant} arb_state_e;

  localparam int unsigned VicCw       = 9;
  localparam int unsigned VicHTotal   = 327;
  localparam int unsigned VicHReset   = 1;
  localparam int unsigned VicHBStart  = 255;
  localparam int unsigned VicHBEnd    = 327;
  localparam int unsigned VicHSStart  = 272;
  localparam int unsigned VicHSEnd    = 304;
  localparam int unsigned VicVTotal   = 262;
  localparam int unsigned VicVBStart  = 223;
  localparam int unsigned VicVBEnd    = 0;
  localparam int unsigned VicVSStart  = 236;
  localparam int unsigned VicVSEnd    = 240;
  localparam int unsigned VicColsLog2 = 5;
  localparam int unsigned VicAw       = 10;

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: a wrapping counter plus two event-registered set/clear flags
// (blank and sync) decoded from the counter value before it advances.
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int unsigned W         = 9,
  parameter int unsigned TOTAL     = 327,
  parameter int unsigned RESET_VAL = 0,
  parameter int unsigned A_SET     = 0,
  parameter int unsigned A_CLR     = 1,
  parameter int unsigned B_SET     = 0,
  parameter int unsigned B_CLR     = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         at_total,
  output logic         a_flag,
  output logic         b_flag
);

  if (A_SET == A_CLR || B_SET == B_CLR) begin : g_bad_pair
    $fatal(1, "vtg_axis_counter: flag set value equals clear value");
  end
  if (A_SET > TOTAL || A_CLR > TOTAL || B_SET > TOTAL || B_CLR > TOTAL ||
      RESET_VAL > TOTAL) begin : g_bad_cmp
    $fatal(1, "vtg_axis_counter: compare value exceeds TOTAL");
  end
  if ($clog2(TOTAL + 1) > W) begin : g_bad_width
    $fatal(1, "vtg_axis_counter: TOTAL does not fit in W bits");
  end

  localparam logic [W-1:0] Total    = W'(TOTAL);
  localparam logic [W-1:0] ResetVal = W'(RESET_VAL);
  localparam logic [W-1:0] ASet     = W'(A_SET);
  localparam logic [W-1:0] AClr     = W'(A_CLR);
  localparam logic [W-1:0] BSet     = W'(B_SET);
  localparam logic [W-1:0] BClr     = W'(B_CLR);

  logic [W-1:0] cnt_q, cnt_d;
  logic         a_q, a_d, b_q, b_d;

  assign at_total = (cnt_q == Total);

  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    if (en) begin
      // Wrap only on the TOTAL compare, never on natural overflow.
      cnt_d = at_total ? '0 : cnt_q + W'(1);
      if (cnt_q == ASet)      a_d = 1'b1;
      else if (cnt_q == AClr) a_d = 1'b0;
      if (cnt_q == BSet)      b_d = 1'b1;
      else if (cnt_q == BClr) b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= ResetVal;
      a_q   <= 1'b0;
      b_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign cnt    = cnt_q;
  assign a_flag = a_q;
  assign b_flag = b_q;

endmodule

// File: rtl/video_timing_gen.sv
// VIC-class raster timing: H/V counters, blank/sync, strobes, per-frame cocktail flip,
// and a video-RAM address port shared between tile fetch and CPU request/ack.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned CW          = VicCw,
  parameter int unsigned H_TOTAL     = VicHTotal,
  parameter int unsigned H_RESET     = VicHReset,
  parameter int unsigned H_BSTART    = VicHBStart,
  parameter int unsigned H_BEND      = VicHBEnd,
  parameter int unsigned H_SSTART    = VicHSStart,
  parameter int unsigned H_SEND      = VicHSEnd,
  parameter int unsigned V_TOTAL     = VicVTotal,
  parameter int unsigned V_BSTART    = VicVBStart,
  parameter int unsigned V_BEND      = VicVBEnd,
  parameter int unsigned V_SSTART    = VicVSStart,
  parameter int unsigned V_SEND      = VicVSEnd,
  parameter bit          HS_POL      = 1'b1,
  parameter bit          VS_POL      = 1'b1,
  parameter int unsigned COLS_LOG2   = VicColsLog2,
  parameter int unsigned AW          = VicAw,
  parameter bit          CPU_ANYTIME = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic          flip,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic [7:0]    hcnt_f,
  output logic [7:0]    vcnt_f,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [AW-1:0] ram_addr,
  output logic          ram_sel_cpu
);

  if (CW < 8) begin : g_bad_cw
    $fatal(1, "video_timing_gen: CW must be at least 8");
  end
  if (COLS_LOG2 < 1 || COLS_LOG2 > 5) begin : g_bad_cols
    $fatal(1, "video_timing_gen: COLS_LOG2 must be 1..5");
  end
  if (AW == 0) begin : g_bad_aw
    $fatal(1, "video_timing_gen: AW must be non-zero");
  end

  localparam int unsigned VidW = 5 + COLS_LOG2;

  logic h_at_total, v_at_total, v_en, h_wrap, v_wrap;
  logic hsync_raw, vsync_raw;

  assign v_en = ce_pix && (hcnt == CW'(H_SSTART));

  vtg_axis_counter #(
    .W(CW), .TOTAL(H_TOTAL), .RESET_VAL(H_RESET),
    .A_SET(H_BSTART), .A_CLR(H_BEND), .B_SET(H_SSTART), .B_CLR(H_SEND)
  ) u_h_axis (
    .clk(clk), .reset_n(reset_n), .en(ce_pix), .cnt(hcnt),
    .at_total(h_at_total), .a_flag(hblank), .b_flag(hsync_raw)
  );

  vtg_axis_counter #(
    .W(CW), .TOTAL(V_TOTAL), .RESET_VAL(0),
    .A_SET(V_BSTART), .A_CLR(V_BEND), .B_SET(V_SSTART), .B_CLR(V_SEND)
  ) u_v_axis (
    .clk(clk), .reset_n(reset_n), .en(v_en), .cnt(vcnt),
    .at_total(v_at_total), .a_flag(vblank), .b_flag(vsync_raw)
  );

  assign h_wrap = ce_pix && h_at_total;
  assign v_wrap = v_en && v_at_total;
  assign hsync  = hsync_raw ^ ~HS_POL;
  assign vsync  = vsync_raw ^ ~VS_POL;

  logic line_start_q, frame_start_q, flip_q;

  // Flip is only taken at the frame boundary so a frame is never drawn half-flipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      flip_q        <= 1'b0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
      if (v_wrap) flip_q <= flip;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hcnt_f      = hcnt[7:0] ^ {8{flip_q}};
  assign vcnt_f      = vcnt[7:0] ^ {8{flip_q}};

  logic [VidW-1:0] vid_addr;
  logic [AW-1:0]   vid_addr_aw;
  logic            grant_ok;

  assign vid_addr    = {vcnt_f[7:3], hcnt_f[COLS_LOG2+2:3]};
  assign vid_addr_aw = AW'(vid_addr);
  // Grant only on a clk without ce_pix so it never lands on a pixel address fetch.
  assign grant_ok    = cpu_req && (hblank || vblank || CPU_ANYTIME) && !ce_pix;

  arb_state_e    state_q;
  logic          cpu_ack_q, ram_sel_cpu_q;
  logic [AW-1:0] ram_addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cpu_ack_q     <= 1'b0;
      ram_sel_cpu_q <= 1'b0;
      ram_addr_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_ok) begin
            state_q       <= StGrant;
            cpu_ack_q     <= 1'b1;
            ram_sel_cpu_q <= 1'b1;
            ram_addr_q    <= cpu_addr;
          end else begin
            cpu_ack_q     <= 1'b0;
            ram_sel_cpu_q <= 1'b0;
            ram_addr_q    <= vid_addr_aw;
          end
        end
        StGrant: begin
          state_q       <= StIdle;
          cpu_ack_q     <= 1'b0;
          ram_sel_cpu_q <= 1'b0;
          ram_addr_q    <= vid_addr_aw;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign ram_sel_cpu = ram_sel_cpu_q;
  assign ram_addr    = ram_addr_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default VIC geometry plus a small-geometry,
// low-polarity instance used for the frame period.
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_pix = 1'b0;
  logic       flip = 1'b0;
  logic       cpu_req = 1'b0;
  logic [9:0] cpu_addr = '0;

  logic       cpu_ack, hblank, vblank, hsync, vsync, line_start, frame_start, ram_sel_cpu;
  logic [8:0] hcnt, vcnt;
  logic [7:0] hcnt_f, vcnt_f;
  logic [9:0] ram_addr;

  logic       s_cpu_ack, s_hblank, s_vblank, s_hsync, s_vsync, s_line_start, s_frame_start;
  logic       s_ram_sel_cpu;
  logic [8:0] s_hcnt, s_vcnt;
  logic [7:0] s_hcnt_f, s_vcnt_f;
  logic [9:0] s_ram_addr;

  int total = 0;
  int bad = 0;
  int ce_count = 0;

  always #5 clk = ~clk;

  video_timing_gen dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .flip(flip), .cpu_req(cpu_req),
    .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .hcnt(hcnt), .vcnt(vcnt), .hcnt_f(hcnt_f),
    .vcnt_f(vcnt_f), .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .ram_addr(ram_addr),
    .ram_sel_cpu(ram_sel_cpu)
  );

  video_timing_gen #(
    .H_TOTAL(15), .H_RESET(1), .H_BSTART(11), .H_BEND(15), .H_SSTART(12), .H_SEND(14),
    .V_TOTAL(9), .V_BSTART(7), .V_BEND(0), .V_SSTART(8), .V_SEND(9),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .flip(flip), .cpu_req(1'b0),
    .cpu_addr(10'd0), .cpu_ack(s_cpu_ack), .hcnt(s_hcnt), .vcnt(s_vcnt), .hcnt_f(s_hcnt_f),
    .vcnt_f(s_vcnt_f), .hblank(s_hblank), .vblank(s_vblank), .hsync(s_hsync),
    .vsync(s_vsync), .line_start(s_line_start), .frame_start(s_frame_start),
    .ram_addr(s_ram_addr), .ram_sel_cpu(s_ram_sel_cpu)
  );

  task automatic step(input logic ce);
    ce_pix = ce;
    @(posedge clk);
    #1;
    if (ce) ce_count++;
  endtask

  task automatic walk_to(input int h, input int v);
    for (int i = 0; i < 90000 && !(int'(hcnt) == h && int'(vcnt) == v); i++) step(1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(1'b1);
    step(1'b1);
    total++; if (hcnt !== 9'd1) begin bad++; $display("FAIL rst_hcnt got=%0d want=1", hcnt); end
    total++; if (vcnt !== 9'd0) begin bad++; $display("FAIL rst_vcnt got=%0d want=0", vcnt); end
    total++; if ({hblank, vblank} !== 2'b00) begin
      bad++; $display("FAIL rst_blank got=%b want=00", {hblank, vblank}); end
    total++; if ({hsync, vsync} !== 2'b00) begin
      bad++; $display("FAIL rst_sync got=%b want=00", {hsync, vsync}); end
    total++; if ({s_hsync, s_vsync} !== 2'b11) begin
      bad++; $display("FAIL rst_sync_lowpol got=%b want=11", {s_hsync, s_vsync}); end
    total++; if ({cpu_ack, ram_sel_cpu, line_start, frame_start} !== 4'b0000) begin
      bad++; $display("FAIL rst_ctl got=%b want=0000",
                      {cpu_ack, ram_sel_cpu, line_start, frame_start}); end
    total++; if (ram_addr !== 10'd0) begin
      bad++; $display("FAIL rst_ram_addr got=%h want=000", ram_addr); end
    total++; if (hcnt_f !== 8'h01) begin
      bad++; $display("FAIL rst_hcnt_f got=%h want=01", hcnt_f); end
    reset_n  = 1'b1;
    ce_count = 0;
  endtask

  task automatic test_hwrap();
    int n = 0;
    do begin step(1'b1); n++; end while (hcnt != 9'd0 && n < 400);
    total++; if (n != 327) begin bad++; $display("FAIL first_wrap_ce got=%0d want=327", n); end
    total++; if (line_start !== 1'b1) begin
      bad++; $display("FAIL line_start_at_wrap got=%b want=1", line_start); end
    total++; if (vcnt !== 9'd1) begin bad++; $display("FAIL vcnt_line0 got=%0d want=1", vcnt); end
    total++; if (hblank !== 1'b0) begin
      bad++; $display("FAIL hblank_at_h0 got=%b want=0", hblank); end
  endtask

  task automatic test_hblank_hsync();
    int n = 0;
    int hs_cnt = 0;
    int hs_first = -1;
    int hs_last = -1;
    do begin
      step(1'b1);
      n++;
      if (n == 1) begin
        total++; if (line_start !== 1'b0) begin
          bad++; $display("FAIL line_start_width got=%b want=0", line_start); end
      end
      if (hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(hcnt);
        hs_last = int'(hcnt);
      end
      if (hcnt == 9'd255) begin
        total++; if (hblank !== 1'b0) begin
          bad++; $display("FAIL hblank_at_255 got=%b want=0", hblank); end
      end
      if (hcnt == 9'd256) begin
        total++; if (hblank !== 1'b1) begin
          bad++; $display("FAIL hblank_at_256 got=%b want=1", hblank); end
      end
      if (hcnt == 9'd327) begin
        total++; if (hblank !== 1'b1) begin
          bad++; $display("FAIL hblank_at_327 got=%b want=1", hblank); end
      end
    end while (hcnt != 9'd0 && n < 400);
    total++; if (n != 328) begin bad++; $display("FAIL line_period got=%0d want=328", n); end
    total++; if (hs_first != 273 || hs_last != 304 || hs_cnt != 32) begin
      bad++; $display("FAIL hsync_window got=%0d..%0d n=%0d want=273..304 n=32",
                      hs_first, hs_last, hs_cnt); end
    total++; if (hblank !== 1'b0) begin
      bad++; $display("FAIL hblank_clear got=%b want=0", hblank); end
    total++; if (vcnt !== 9'd2) begin bad++; $display("FAIL vcnt_line1 got=%0d want=2", vcnt); end
  endtask

  task automatic test_cpu_grant();
    int acks = 0;
    cpu_addr = 10'h2A5;
    cpu_req  = 1'b1;
    for (int i = 0; i < 1000 && hcnt != 9'd256; i++) begin
      step(1'b0); if (cpu_ack) acks++;
      step(1'b1); if (cpu_ack) acks++;
    end
    total++; if (acks != 0 || hcnt !== 9'd256) begin
      bad++; $display("FAIL no_grant_active got=%0d acks h=%0d want=0 acks h=256", acks, hcnt); end
    step(1'b1);
    total++; if (cpu_ack !== 1'b0) begin
      bad++; $display("FAIL grant_blocked_by_ce got=%b want=0", cpu_ack); end
    step(1'b0);
    total++; if ({cpu_ack, ram_sel_cpu} !== 2'b11 || ram_addr !== 10'h2A5) begin
      bad++; $display("FAIL grant1 got=%b%b addr=%h want=11 addr=2a5",
                      cpu_ack, ram_sel_cpu, ram_addr); end
    cpu_addr = 10'h1C3;
    step(1'b0);
    total++; if ({cpu_ack, ram_sel_cpu} !== 2'b00 || ram_addr !== 10'h000) begin
      bad++; $display("FAIL grant_gap got=%b%b addr=%h want=00 addr=000",
                      cpu_ack, ram_sel_cpu, ram_addr); end
    step(1'b0);
    total++; if ({cpu_ack, ram_sel_cpu} !== 2'b11 || ram_addr !== 10'h1C3) begin
      bad++; $display("FAIL grant2 got=%b%b addr=%h want=11 addr=1c3",
                      cpu_ack, ram_sel_cpu, ram_addr); end
    cpu_req = 1'b0;
    step(1'b0);
    step(1'b0);
    total++; if (cpu_ack !== 1'b0) begin
      bad++; $display("FAIL no_ack_after_drop got=%b want=0", cpu_ack); end
  endtask

  task automatic test_video_addr();
    walk_to(80, 100);
    total++; if (hcnt !== 9'd80 || vcnt !== 9'd100) begin
      bad++; $display("FAIL reach_v100 got=%0d/%0d want=80/100", hcnt, vcnt); end
    total++; if (ram_addr !== 10'h189) begin
      bad++; $display("FAIL vid_addr_latency got=%h want=189", ram_addr); end
    step(1'b0);
    total++; if (ram_addr !== 10'h18A || ram_sel_cpu !== 1'b0) begin
      bad++; $display("FAIL vid_addr got=%h sel=%b want=18a sel=0", ram_addr, ram_sel_cpu); end
    flip = 1'b1;
    step(1'b1);
    total++; if (hcnt_f !== 8'h51 || vcnt_f !== 8'h64) begin
      bad++; $display("FAIL flip_midframe got=%h/%h want=51/64", hcnt_f, vcnt_f); end
  endtask

  task automatic test_vertical();
    walk_to(272, 223);
    total++; if (vblank !== 1'b0 || vcnt !== 9'd223) begin
      bad++; $display("FAIL vblank_pre got=%b v=%0d want=0 v=223", vblank, vcnt); end
    step(1'b1);
    total++; if (vblank !== 1'b1) begin bad++; $display("FAIL vblank_set got=%b want=1", vblank); end
    walk_to(272, 236);
    total++; if (vsync !== 1'b0) begin bad++; $display("FAIL vsync_pre got=%b want=0", vsync); end
    step(1'b1);
    total++; if (vsync !== 1'b1) begin bad++; $display("FAIL vsync_set got=%b want=1", vsync); end
    walk_to(272, 240);
    total++; if (vsync !== 1'b1) begin bad++; $display("FAIL vsync_hold got=%b want=1", vsync); end
    step(1'b1);
    total++; if (vsync !== 1'b0) begin bad++; $display("FAIL vsync_clr got=%b want=0", vsync); end
    walk_to(272, 262);
    total++; if (hcnt_f !== 8'h10 || frame_start !== 1'b0) begin
      bad++; $display("FAIL pre_frame got=%h fs=%b want=10 fs=0", hcnt_f, frame_start); end
    step(1'b1);
    total++; if (frame_start !== 1'b1 || vcnt !== 9'd0 || vblank !== 1'b1) begin
      bad++; $display("FAIL frame_start got=%b v=%0d vb=%b want=1 v=0 vb=1",
                      frame_start, vcnt, vblank); end
    total++; if (ce_count != 86208) begin
      bad++; $display("FAIL first_frame_ce got=%0d want=86208", ce_count); end
    total++; if (hcnt_f !== 8'hEE || vcnt_f !== 8'hFF) begin
      bad++; $display("FAIL flip_taken got=%h/%h want=ee/ff", hcnt_f, vcnt_f); end
    walk_to(5, 0);
    total++; if (hcnt_f !== 8'hFA) begin
      bad++; $display("FAIL flip_h5 got=%h want=fa", hcnt_f); end
    walk_to(272, 0);
    step(1'b1);
    total++; if (vblank !== 1'b0 || vcnt !== 9'd1) begin
      bad++; $display("FAIL vblank_clr got=%b v=%0d want=0 v=1", vblank, vcnt); end
  endtask

  task automatic test_frame_period();
    int n = 0;
    for (int i = 0; i < 400 && !s_frame_start; i++) step(1'b1);
    do begin step(1'b1); n++; end while (!s_frame_start && n < 400);
    total++; if (n != 160 || s_vcnt !== 9'd0) begin
      bad++; $display("FAIL small_frame_period got=%0d v=%0d want=160 v=0", n, s_vcnt); end
  endtask

  task automatic test_reset_mid_grant();
    int acks = 0;
    for (int i = 0; i < 400 && !hblank; i++) step(1'b1);
    cpu_addr = 10'h0F0;
    cpu_req  = 1'b1;
    step(1'b0);
    total++; if (cpu_ack !== 1'b1) begin
      bad++; $display("FAIL pre_reset_grant got=%b want=1", cpu_ack); end
    #1 reset_n = 1'b0;
    #1;
    total++; if ({cpu_ack, ram_sel_cpu} !== 2'b00 || hcnt !== 9'd1 || vcnt !== 9'd0) begin
      bad++; $display("FAIL reset_mid_grant got=%b%b h=%0d v=%0d want=00 h=1 v=0",
                      cpu_ack, ram_sel_cpu, hcnt, vcnt); end
    total++; if (hcnt_f !== 8'h01) begin
      bad++; $display("FAIL reset_flip got=%h want=01", hcnt_f); end
    step(1'b0);
    step(1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 1000 && hcnt != 9'd256; i++) begin
      step(1'b0); if (cpu_ack) acks++;
      step(1'b1); if (cpu_ack) acks++;
    end
    total++; if (acks != 0 || hcnt !== 9'd256) begin
      bad++; $display("FAIL post_reset_active got=%0d acks h=%0d want=0 acks h=256", acks, hcnt); end
    step(1'b0);
    total++; if ({cpu_ack, ram_sel_cpu} !== 2'b11 || ram_addr !== 10'h0F0) begin
      bad++; $display("FAIL post_reset_grant got=%b%b addr=%h want=11 addr=0f0",
                      cpu_ack, ram_sel_cpu, ram_addr); end
    cpu_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hwrap();
    test_hblank_hsync();
    test_cpu_grant();
    test_video_addr();
    test_vertical();
    test_frame_period();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
